mux4_sel_arbiter: RTL and testbench



---
 rtl/mux4_sel_arbiter.sv | 140 ++++++++++++++
 tb/tb_mux4_sel_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_sel_arbiter.sv
// Round-robin arbiter that drives the select lines of a 4:1 mux, limits each grant with a hold
// counter and returns the mux output as a registered sample stream. FIXED_PRIO_EN: fixed priority.
module mux4_sel_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       mux_out,
   output logic       s0,
   output logic       s1,
   output logic [3:0] gnt,
   output logic       busy,
   output logic       data_q,
   output logic       data_vld
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t              state, state_d;
   logic [1:0]          sel, sel_d;
   logic [3:0]          gnt_d;
   logic [HOLD_W-1:0]   hold_cnt, hold_d;
   logic                busy_d, data_q_d, data_vld_d;
   logic [1:0]          winner;
`ifndef FIXED_PRIO_EN
   logic [1:0]          rr_ptr, rr_d;
`endif

   assign s0 = sel[0];
   assign s1 = sel[1];

`ifdef FIXED_PRIO_EN
   // Scan from the highest index down so the lowest asserted request is the last write.
   always_comb begin
      winner = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (req[i]) winner = 2'(i);
      end
   end
`else
   // Scan rr_ptr+4 (= rr_ptr) down to rr_ptr+1; the nearest channel after the pointer wins.
   always_comb begin
      logic [1:0] cand;
      winner = 2'd0;
      cand   = 2'd0;
      for (int i = 4; i >= 1; i--) begin
         cand = rr_ptr + 2'(i);
         if (req[cand]) winner = cand;
      end
   end
`endif

   // NOTE: every signal gets its hold value first, so no path through the case can infer a latch.
   always_comb begin
      state_d    = state;
      sel_d      = sel;
      gnt_d      = gnt;
      hold_d     = hold_cnt;
      busy_d     = busy;
      data_q_d   = data_q;
      data_vld_d = data_vld;
`ifndef FIXED_PRIO_EN
      rr_d       = rr_ptr;
`endif
      case (state)
         IDLE: begin
            gnt_d      = 4'b0000;
            busy_d     = 1'b0;
            data_vld_d = 1'b0;
            if (|req) begin
               state_d = GRANT;
               gnt_d   = 4'b0001 << winner;
               sel_d   = winner;
               hold_d  = '0;
               busy_d  = 1'b1;
`ifndef FIXED_PRIO_EN
               rr_d    = winner;
`endif
            end
         end
         GRANT: begin
            // The exit edge still samples: the mux is valid for the whole last grant cycle.
            data_q_d   = mux_out;
            data_vld_d = 1'b1;
            busy_d     = 1'b1;
            hold_d     = hold_cnt + HOLD_W'(1);
            if (!req[sel] || hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
               state_d = RELEASE;
               gnt_d   = 4'b0000;
            end
         end
         RELEASE: begin
            state_d    = IDLE;
            gnt_d      = 4'b0000;
            busy_d     = 1'b0;
            data_vld_d = 1'b0;
         end
         default: begin
            state_d    = IDLE;
            gnt_d      = 4'b0000;
            busy_d     = 1'b0;
            data_vld_d = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel      <= 2'd0;
         gnt      <= 4'b0000;
         hold_cnt <= '0;
         busy     <= 1'b0;
         data_q   <= 1'b0;
         data_vld <= 1'b0;
`ifndef FIXED_PRIO_EN
         rr_ptr   <= 2'd3;
`endif
      end else begin
         state    <= state_d;
         sel      <= sel_d;
         gnt      <= gnt_d;
         hold_cnt <= hold_d;
         busy     <= busy_d;
         data_q   <= data_q_d;
         data_vld <= data_vld_d;
`ifndef FIXED_PRIO_EN
         rr_ptr   <= rr_d;
`endif
      end
   end

endmodule

// File: tb/tb_mux4_sel_arbiter.sv
// Scoreboard bench for mux4_sel_arbiter: a grant-bookkeeping model predicts outputs and sampled
// data; a separate monitor pops expected samples whenever data_vld is high.
module tb_mux4_sel_arbiter;

   localparam int MAX_HOLD = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] din;
   logic       mux_out;
   logic       s0, s1;
   logic [3:0] gnt;
   logic       busy, data_q, data_vld;

   int checks = 0;
   int errors = 0;

   // Expected data samples, channel grant log and observed data stream.
   logic exp_q[$];
   logic d_log[$];
   int   g_ch_q[$];
   int   g_len_q[$];
   int   run_len = 0;
   int   run_ch  = 0;

   // Model: phase 0 = idle, 1 = granted, 2 = dead cycle.
   int         m_phase, m_cur, m_len, m_ptr;
   logic [1:0] m_sel;
   logic       m_dv;

   always #5 clk = ~clk;

   // The 4:1 mux being steered: input k is din[k].
   assign mux_out = din[{s1, s0}];

   mux4_sel_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .mux_out  (mux_out),
      .s0       (s0),
      .s1       (s1),
      .gnt      (gnt),
      .busy     (busy),
      .data_q   (data_q),
      .data_vld (data_vld)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int ptr);
`ifdef FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
      for (int k = 1; k <= 4; k++) if (r[(ptr + k) % 4]) return (ptr + k) % 4;
`endif
      return 0;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_cur = 0; m_len = 0; m_ptr = 3; m_sel = 2'd0; m_dv = 1'b0;
      exp_q.delete();
      run_len = 0;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step(input logic [3:0] r, input logic [3:0] d);
      case (m_phase)
         0: begin
            m_dv = 1'b0;
            if (r != 4'b0000) begin
               m_cur = pick(r, m_ptr);
               m_ptr = m_cur;
               m_sel = 2'(m_cur);
               m_len = 1;
               m_phase = 1;
            end
         end
         1: begin
            m_dv = 1'b1;
            exp_q.push_back(d[m_sel]);
            if (!r[m_cur] || m_len == MAX_HOLD) m_phase = 2;
            else m_len++;
         end
         default: begin
            m_dv = 1'b0;
            m_phase = 0;
         end
      endcase
   endtask

   // Scoreboard monitor: pops one expected sample for every valid output cycle.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && data_vld === 1'b1) begin
         d_log.push_back(data_q);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got data_q %0b expected no valid sample at %0t", data_q, $time);
         end else begin
            check("data_q", data_q, exp_q.pop_front());
         end
      end
   end

   // One clock: drive inputs, compare at the falling edge, then step the model.
   task automatic cycle(input logic [3:0] r, input logic [3:0] d);
      logic [3:0] exp_gnt;
      req = r;
      din = d;
      @(negedge clk);
      exp_gnt = (m_phase == 1) ? 4'(1 << m_cur) : 4'b0000;
      check("gnt", gnt, exp_gnt);
      check("sel", {s1, s0}, m_sel);
      check("busy", busy, m_phase != 0);
      check("data_vld", data_vld, m_dv);
      if (gnt != 4'b0000) begin
         if (run_len == 0) for (int i = 0; i < 4; i++) if (gnt[i]) run_ch = i;
         run_len++;
      end else if (run_len != 0) begin
         g_ch_q.push_back(run_ch);
         g_len_q.push_back(run_len);
         run_len = 0;
      end
      model_step(r, d);
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [3:0] r, input int n);
      for (int i = 0; i < n; i++) cycle(r, 4'($urandom));
   endtask

   // Compare the grant log against n channels (2 bits each, first in LSB) all of length len.
   task automatic expect_grants(input string nm, input int n, input logic [15:0] chs, input int len);
      check({nm, "_count"}, g_ch_q.size(), n);
      for (int i = 0; i < n && i < g_ch_q.size(); i++) begin
         check({nm, "_ch"}, g_ch_q[i], chs[2*i +: 2]);
         check({nm, "_len"}, g_len_q[i], len);
      end
      g_ch_q.delete();
      g_len_q.delete();
   endtask

   initial begin
      logic [3:0] rr;
      rst_n = 1'b0;
      req   = 4'b0000;
      din   = 4'b0000;
      model_reset();
      @(negedge clk);
      check("rst_gnt", gnt, 4'b0000);
      check("rst_sel", {s1, s0}, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_data_q", data_q, 1'b0);
      check("rst_vld", data_vld, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset mid-grant of channel 2 clears outputs without a clock edge.
      run(4'b0100, 3);
      check("pre_rst_gnt", gnt, 4'b0100);
      #2 rst_n = 1'b0;
      #1;
      check("async_gnt", gnt, 4'b0000);
      check("async_sel", {s1, s0}, 2'b00);
      check("async_vld", data_vld, 1'b0);
      check("async_busy", busy, 1'b0);
      model_reset();
      g_ch_q.delete();
      g_len_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // All requesting: rotation 0,1,2,3,0 straight out of reset, each at the hold limit.
      run(4'b1111, 50);
      run(4'b0000, 2);
`ifdef FIXED_PRIO_EN
      expect_grants("rr", 5, 16'h0000, MAX_HOLD);
`else
      expect_grants("rr", 5, 16'h00E4, MAX_HOLD);
`endif

      // Single request on channel 2 for three grant cycles, mux input 2 = 1,0,1.
      d_log.delete();
      cycle(4'b0100, 4'b0000);
      cycle(4'b0100, 4'b0100);
      cycle(4'b0100, 4'b1011);
      cycle(4'b0000, 4'b0100);
      run(4'b0000, 3);
      expect_grants("single", 1, 16'h0002, 3);
      check("single_nvld", d_log.size(), 3);
      if (d_log.size() == 3) begin
         check("single_d0", d_log[0], 1'b1);
         check("single_d1", d_log[1], 1'b0);
         check("single_d2", d_log[2], 1'b1);
      end

      // After a channel 2 grant, requests 0 and 1 wrap around to 0 then 1.
      run(4'b0011, 20);
      run(4'b0000, 2);
`ifdef FIXED_PRIO_EN
      expect_grants("wrap", 2, 16'h0000, MAX_HOLD);
`else
      expect_grants("wrap", 2, 16'h0004, MAX_HOLD);
`endif
      run(4'b1010, 10);
      run(4'b0000, 2);
`ifdef FIXED_PRIO_EN
      expect_grants("pri1010", 1, 16'h0001, MAX_HOLD);
`else
      expect_grants("pri1010", 1, 16'h0003, MAX_HOLD);
`endif

      // Held request is cut at the hold limit and regranted after the dead cycle.
      run(4'b0001, 20);
      run(4'b0000, 2);
      expect_grants("hold", 2, 16'h0000, MAX_HOLD);

      // Request drop coinciding with hold expiry gives one clean exit.
      run(4'b0001, 8);
      run(4'b0000, 4);
      expect_grants("glitch", 1, 16'h0000, MAX_HOLD);

      // Random traffic with sticky requests.
      rr = 4'b0000;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) rr = 4'($urandom);
         cycle(rr, 4'($urandom));
      end
      run(4'b0000, 4);
      check("sb_drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
